// File: rtl/ps2_matrix_if.sv
// Host/line-side bundle for ps2_matrix: PS/2 pins, keymap write port,
// matrix scan port and the decoded key-event stream.
interface ps2_matrix_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
);
  logic            ce;
  logic [1:0]      ps2;
  logic            map_we;
  logic [8:0]      map_addr;
  logic [8:0]      map_data;
  logic            ready;
  logic            clear;
  logic [ROWS-1:0] a;
  logic [COLS-1:0] q;
  logic            key_valid;
  logic [8:0]      key_code;
  logic            key_pressed;
  logic            err;

  modport master (
    output ce, ps2, map_we, map_addr, map_data, clear, a,
    input  ready, q, key_valid, key_code, key_pressed, err
  );

  modport slave (
    input  ce, ps2, map_we, map_addr, map_data, clear, a,
    output ready, q, key_valid, key_code, key_pressed, err
  );
endinterface

// File: rtl/ps2_matrix.sv
// PS/2 keyboard receiver with prefix decoding and a programmable 512-entry
// keymap driving a ROWS x COLS key matrix scanned by an active-high row select.
module ps2_matrix #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned TIMEOUT = 2000
) (
  input logic         clock,
  input logic         nreset,
  ps2_matrix_if.slave bus
);
  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam int unsigned MAP_DEPTH = 512;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Post-reset sweep that invalidates every keymap entry
  logic [8:0] sweep_idx;
  logic       ready_q;
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sweep_idx <= '0;
      ready_q   <= 1'b0;
    end else if (!ready_q) begin
      sweep_idx <= sweep_idx + 9'd1;
      if (sweep_idx == 9'd511) ready_q <= 1'b1;
    end
  end
  assign bus.ready = ready_q;

  logic [8:0] map_mem [MAP_DEPTH];
  always_ff @(posedge clock) begin
    if (!ready_q)        map_mem[sweep_idx]    <= '0;
    else if (bus.map_we) map_mem[bus.map_addr] <= bus.map_data;
  end

  // PS/2 clock glitch filter; tick marks a filtered falling edge
  logic [7:0] clk_sr;
  logic       clk_lvl;
  logic       tick;
  logic       dat;
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      clk_sr  <= '1;
      clk_lvl <= 1'b1;
      tick    <= 1'b0;
      dat     <= 1'b1;
    end else begin
      tick <= 1'b0;
      if (bus.ce) begin
        clk_sr <= {clk_sr[6:0], bus.ps2[0]};
        dat    <= bus.ps2[1];
        if (clk_sr == 8'hFF) begin
          clk_lvl <= 1'b1;
        end else if (clk_sr == 8'h00) begin
          clk_lvl <= 1'b0;
          tick    <= clk_lvl;
        end
      end
    end
  end

  rx_state_t state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          byte_ok;
  logic [7:0]    rx_byte;
  logic          frame_err;
  logic          timed_out_c;

  assign timed_out_c = (state != IDLE) && (to_cnt == TW'(TIMEOUT));

  // Frame receiver; a stalled partial frame is abandoned by the timeout
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      byte_ok   <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      if (timed_out_c) begin
        state  <= IDLE;
        to_cnt <= '0;
      end else begin
        if (tick || state == IDLE) to_cnt <= '0;
        else if (bus.ce)           to_cnt <= to_cnt + TW'(1);
        if (tick) begin
          case (state)
            IDLE: begin
              if (!dat) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shreg   <= {dat, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              if (^{shreg, dat}) begin
                state <= STOP;
              end else begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end
            default: begin
              state <= IDLE;
              if (dat) begin
                byte_ok <= 1'b1;
                rx_byte <= shreg;
              end else begin
                frame_err <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // Prefix handling and event generation
  logic       ext_q;
  logic       rel_q;
  logic       kvalid;
  logic [8:0] kcode;
  logic       kpressed;
  logic       err_q;
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      kvalid   <= 1'b0;
      kcode    <= '0;
      kpressed <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      kvalid <= 1'b0;
      err_q  <= frame_err | timed_out_c;
      if (byte_ok) begin
        if (rx_byte == 8'hF0) begin
          rel_q <= 1'b1;
        end else if (rx_byte == 8'hE0) begin
          ext_q <= 1'b1;
        end else begin
          kvalid   <= 1'b1;
          kcode    <= {ext_q, rx_byte};
          kpressed <= ~rel_q;
          ext_q    <= 1'b0;
          rel_q    <= 1'b0;
        end
      end
    end
  end
  assign bus.key_valid   = kvalid;
  assign bus.key_code    = kcode;
  assign bus.key_pressed = kpressed;
  assign bus.err         = err_q;

  // Asynchronous read gives read-first behaviour against a same-clock write
  logic [8:0] entry_c;
  assign entry_c = map_mem[kcode];

  logic [ROWS-1:0][COLS-1:0] keys;
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      keys <= '0;
    end else if (bus.clear) begin
      keys <= '0;
    end else if (kvalid && entry_c[8]) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          if (entry_c[7:4] == 4'(r) && entry_c[3:0] == 4'(c)) keys[r][c] <= kpressed;
    end
  end

  logic [COLS-1:0] q_c;
  always_comb begin
    q_c = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      if (bus.a[r]) q_c = q_c | keys[r];
  end
  assign bus.q = q_c;
endmodule
